// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves load-use, taken-redirect and data-memory
// wait hazards into hold/flush/bubble/stall controls for a 5-stage pipeline.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic        i_ex_valid,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_redirect,
  input  logic        i_dmem_req,
  input  logic        i_dmem_ack,
  output logic        o_pc_hold,
  output logic        o_ifid_hold,
  output logic        o_ifid_flush,
  output logic        o_idex_bubble,
  output logic        o_mem_stall,
  output logic [1:0]  o_state,
  output logic [31:0] o_stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // Counter holds the FLUSH cycles still to run, including the current one.
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0] FLUSH_FULL = 2'(FLUSH_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  flush_cnt;
  logic [1:0]  flush_cnt_nxt;
  logic        ret_flush;
  logic        ret_flush_nxt;
  logic        redir_pend;
  logic        redir_pend_nxt;
  logic        load_use;
  logic        mem_wait_cond;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        mem_stall;
  logic [31:0] stall_count;

  assign load_use = i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0) & i_id_valid &
                    ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                     (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

  assign mem_wait_cond = i_dmem_req & ~i_dmem_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_RUN;
      flush_cnt  <= 2'd0;
      ret_flush  <= 1'b0;
      redir_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      ret_flush  <= ret_flush_nxt;
      redir_pend <= redir_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    ret_flush_nxt  = ret_flush;
    redir_pend_nxt = redir_pend;
    case (state)
      ST_RUN: begin
        if (mem_wait_cond) begin
          // A redirect shadowed by the memory stall is replayed after the ack.
          state_nxt      = ST_MEM_WAIT;
          ret_flush_nxt  = 1'b0;
          redir_pend_nxt = i_ex_redirect;
        end else if (i_ex_redirect && (FLUSH_CYCLES > 1)) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = FLUSH_INIT;
        end
      end
      ST_FLUSH: begin
        if (mem_wait_cond) begin
          state_nxt      = ST_MEM_WAIT;
          ret_flush_nxt  = 1'b1;
          redir_pend_nxt = 1'b0;
        end else if (flush_cnt <= 2'd1) begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = 2'd0;
        end else begin
          flush_cnt_nxt = flush_cnt - 2'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (!ret_flush) begin
          redir_pend_nxt = redir_pend | i_ex_redirect;
        end
        if (i_dmem_ack) begin
          redir_pend_nxt = 1'b0;
          ret_flush_nxt  = 1'b0;
          if (ret_flush) begin
            state_nxt = ST_FLUSH;
          end else if (redir_pend || i_ex_redirect) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FLUSH_FULL;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        state_nxt      = ST_RUN;
        flush_cnt_nxt  = 2'd0;
        ret_flush_nxt  = 1'b0;
        redir_pend_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mem_stall   = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_wait_cond) begin
          mem_stall = 1'b1;
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
        end else if (i_ex_redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (mem_wait_cond) begin
          mem_stall = 1'b1;
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
        end else begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!i_dmem_ack) begin
          mem_stall = 1'b1;
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
        end
      end
      default: begin
        pc_hold = 1'b0;
      end
    endcase
  end

  assign o_pc_hold     = pc_hold & ~i_rst;
  assign o_ifid_hold   = ifid_hold & ~i_rst;
  assign o_ifid_flush  = ifid_flush & ~i_rst;
  assign o_idex_bubble = idex_bubble & ~i_rst;
  assign o_mem_stall   = mem_stall & ~i_rst;
  assign o_state       = state;
  assign o_stall_count = stall_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_count <= 32'd0;
    end else if (o_pc_hold && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(o_ifid_hold && o_ifid_flush));
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (FLUSH_CYCLES=2): each vector pushes its
// expected controls/state/count when driven, popped at the following negedge.
module tb_hazard_ctrl;

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b11001;
  localparam logic [4:0] LU    = 5'b11010;
  localparam logic [4:0] FL    = 5'b00110;

  typedef struct packed {
    logic       rst;
    logic       idv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       exv;
    logic       exld;
    logic [4:0] rd;
    logic       redir;
    logic       req;
    logic       ack;
    logic [4:0] ctl;
    logic [1:0] st;
    logic       chk;
  } vec_t;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic        chk;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        dmem_req;
  logic        dmem_ack;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        mem_stall;
  logic [1:0]  state;
  logic [31:0] stall_count;
  logic [4:0]  ctl;

  sb_t         sb[$];
  logic [31:0] model_cnt = 32'd0;
  int          tests = 0;
  int          failed = 0;

  assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, mem_stall};

  hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_valid    (ex_valid),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rd       (ex_rd),
    .i_ex_redirect (ex_redirect),
    .i_dmem_req    (dmem_req),
    .i_dmem_ack    (dmem_ack),
    .o_pc_hold     (pc_hold),
    .o_ifid_hold   (ifid_hold),
    .o_ifid_flush  (ifid_flush),
    .o_idex_bubble (idex_bubble),
    .o_mem_stall   (mem_stall),
    .o_state       (state),
    .o_stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic redir, input logic req,
                              input logic ack, input logic [4:0] c, input logic [1:0] s);
    vec_t t;
    t = '0;
    t.rst = r;
    t.redir = redir;
    t.req = req;
    t.ack = ack;
    t.ctl = c;
    t.st = s;
    t.chk = 1'b1;
    return t;
  endfunction

  function automatic vec_t lu(input vec_t b, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1, input logic u2);
    vec_t t;
    t = b;
    t.exv = 1'b1;
    t.exld = 1'b1;
    t.idv = 1'b1;
    t.rd = rd;
    t.rs1 = rs1;
    t.rs2 = rs2;
    t.u1 = u1;
    t.u2 = u2;
    return t;
  endfunction

  task automatic apply(input vec_t v);
    sb_t e;
    rst = v.rst;
    id_valid = v.idv;
    id_rs1 = v.rs1;
    id_rs2 = v.rs2;
    id_uses_rs1 = v.u1;
    id_uses_rs2 = v.u2;
    ex_valid = v.exv;
    ex_mem_read = v.exld;
    ex_rd = v.rd;
    ex_redirect = v.redir;
    dmem_req = v.req;
    dmem_ack = v.ack;
    e.ctl = v.ctl;
    e.st = v.st;
    e.cnt = model_cnt;
    e.chk = v.chk;
    sb.push_back(e);
    model_cnt = v.rst ? 32'd0 : model_cnt + {31'd0, v.ctl[4]};
  endtask

  task automatic test_reset();
    vec_t v[$];
    vec_t t;
    sb_t e;
    t = lu(mk(1, 0, 1, 0, NONE, 0), 5, 5, 0, 1, 0);
    t.chk = 1'b0;
    v.push_back(t);
    v.push_back(mk(1, 0, 0, 0, NONE, 0));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    foreach (v[i]) begin
      @(posedge clk); #1;
      apply(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (ctl !== e.ctl) begin failed++; $display("FAIL reset[%0d] ctl got %b want %b", i, ctl, e.ctl); end
      if (e.chk) begin
        tests++;
        if (state !== e.st) begin failed++; $display("FAIL reset[%0d] state got %0d want %0d", i, state, e.st); end
        tests++;
        if (stall_count !== e.cnt) begin failed++; $display("FAIL reset[%0d] count got %0d want %0d", i, stall_count, e.cnt); end
      end
    end
  endtask

  task automatic test_load_use();
    vec_t v[$];
    vec_t t;
    sb_t e;
    v.push_back(lu(mk(0, 0, 0, 0, LU, 0), 5, 3, 5, 1, 1));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    v.push_back(lu(mk(0, 0, 0, 0, LU, 0), 7, 7, 2, 1, 0));
    v.push_back(lu(mk(0, 0, 0, 0, NONE, 0), 7, 2, 7, 1, 0));
    t = lu(mk(0, 0, 0, 0, NONE, 0), 7, 7, 7, 1, 1); t.idv = 1'b0;
    v.push_back(t);
    t = lu(mk(0, 0, 0, 0, NONE, 0), 7, 7, 7, 1, 1); t.exld = 1'b0;
    v.push_back(t);
    t = lu(mk(0, 0, 0, 0, NONE, 0), 7, 7, 7, 1, 1); t.exv = 1'b0;
    v.push_back(t);
    v.push_back(lu(mk(0, 0, 0, 0, NONE, 0), 0, 0, 0, 1, 1));
    foreach (v[i]) begin
      @(posedge clk); #1;
      apply(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (ctl !== e.ctl) begin failed++; $display("FAIL load_use[%0d] ctl got %b want %b", i, ctl, e.ctl); end
      tests++;
      if (state !== e.st) begin failed++; $display("FAIL load_use[%0d] state got %0d want %0d", i, state, e.st); end
      tests++;
      if (stall_count !== e.cnt) begin failed++; $display("FAIL load_use[%0d] count got %0d want %0d", i, stall_count, e.cnt); end
    end
  endtask

  task automatic test_flush();
    vec_t v[$];
    sb_t e;
    v.push_back(lu(mk(0, 1, 0, 0, FL, 0), 4, 4, 0, 1, 0));
    v.push_back(lu(mk(0, 1, 0, 0, FL, 1), 4, 4, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    foreach (v[i]) begin
      @(posedge clk); #1;
      apply(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (ctl !== e.ctl) begin failed++; $display("FAIL flush[%0d] ctl got %b want %b", i, ctl, e.ctl); end
      tests++;
      if (state !== e.st) begin failed++; $display("FAIL flush[%0d] state got %0d want %0d", i, state, e.st); end
      tests++;
      if (stall_count !== e.cnt) begin failed++; $display("FAIL flush[%0d] count got %0d want %0d", i, stall_count, e.cnt); end
    end
  endtask

  task automatic test_mem_wait();
    vec_t v[$];
    sb_t e;
    v.push_back(mk(0, 0, 1, 0, STALL, 0));
    v.push_back(lu(mk(0, 0, 1, 0, STALL, 2), 6, 6, 0, 1, 0));
    v.push_back(mk(0, 0, 1, 0, STALL, 2));
    v.push_back(mk(0, 0, 1, 1, NONE, 2));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    v.push_back(mk(0, 0, 0, 1, NONE, 0));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    foreach (v[i]) begin
      @(posedge clk); #1;
      apply(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (ctl !== e.ctl) begin failed++; $display("FAIL mem_wait[%0d] ctl got %b want %b", i, ctl, e.ctl); end
      tests++;
      if (state !== e.st) begin failed++; $display("FAIL mem_wait[%0d] state got %0d want %0d", i, state, e.st); end
      tests++;
      if (stall_count !== e.cnt) begin failed++; $display("FAIL mem_wait[%0d] count got %0d want %0d", i, stall_count, e.cnt); end
    end
  endtask

  task automatic test_redirect_mem();
    vec_t v[$];
    sb_t e;
    v.push_back(mk(0, 1, 1, 0, STALL, 0));
    v.push_back(mk(0, 0, 1, 0, STALL, 2));
    v.push_back(mk(0, 0, 1, 1, NONE, 2));
    v.push_back(mk(0, 0, 0, 0, FL, 1));
    v.push_back(mk(0, 0, 0, 0, FL, 1));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    foreach (v[i]) begin
      @(posedge clk); #1;
      apply(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (ctl !== e.ctl) begin failed++; $display("FAIL redirect_mem[%0d] ctl got %b want %b", i, ctl, e.ctl); end
      tests++;
      if (state !== e.st) begin failed++; $display("FAIL redirect_mem[%0d] state got %0d want %0d", i, state, e.st); end
      tests++;
      if (stall_count !== e.cnt) begin failed++; $display("FAIL redirect_mem[%0d] count got %0d want %0d", i, stall_count, e.cnt); end
    end
  endtask

  task automatic test_flush_mem();
    vec_t v[$];
    sb_t e;
    v.push_back(mk(0, 1, 0, 0, FL, 0));
    v.push_back(mk(0, 0, 1, 0, STALL, 1));
    v.push_back(mk(0, 0, 1, 0, STALL, 2));
    v.push_back(mk(0, 0, 1, 1, NONE, 2));
    v.push_back(lu(mk(0, 0, 0, 0, FL, 1), 5, 5, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    foreach (v[i]) begin
      @(posedge clk); #1;
      apply(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (ctl !== e.ctl) begin failed++; $display("FAIL flush_mem[%0d] ctl got %b want %b", i, ctl, e.ctl); end
      tests++;
      if (state !== e.st) begin failed++; $display("FAIL flush_mem[%0d] state got %0d want %0d", i, state, e.st); end
      tests++;
      if (stall_count !== e.cnt) begin failed++; $display("FAIL flush_mem[%0d] count got %0d want %0d", i, stall_count, e.cnt); end
    end
  endtask

  task automatic test_reset_abort();
    vec_t v[$];
    sb_t e;
    v.push_back(mk(0, 0, 1, 0, STALL, 0));
    v.push_back(mk(0, 0, 1, 0, STALL, 2));
    v.push_back(mk(1, 0, 1, 0, NONE, 2));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    v.push_back(mk(0, 1, 0, 0, FL, 0));
    v.push_back(mk(1, 0, 0, 0, NONE, 1));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    foreach (v[i]) begin
      @(posedge clk); #1;
      apply(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (ctl !== e.ctl) begin failed++; $display("FAIL reset_abort[%0d] ctl got %b want %b", i, ctl, e.ctl); end
      tests++;
      if (state !== e.st) begin failed++; $display("FAIL reset_abort[%0d] state got %0d want %0d", i, state, e.st); end
      tests++;
      if (stall_count !== e.cnt) begin failed++; $display("FAIL reset_abort[%0d] count got %0d want %0d", i, stall_count, e.cnt); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    sb_t e;
    v.push_back(lu(mk(0, 0, 0, 0, LU, 0), 9, 9, 1, 1, 0));
    v.push_back(lu(mk(0, 0, 0, 0, LU, 0), 9, 9, 1, 1, 0));
    v.push_back(mk(0, 0, 1, 1, NONE, 0));
    v.push_back(mk(0, 1, 0, 0, FL, 0));
    v.push_back(mk(0, 0, 0, 0, FL, 1));
    v.push_back(lu(mk(0, 0, 0, 0, LU, 0), 3, 0, 3, 0, 1));
    v.push_back(mk(0, 0, 0, 0, NONE, 0));
    foreach (v[i]) begin
      @(posedge clk); #1;
      apply(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (ctl !== e.ctl) begin failed++; $display("FAIL back_to_back[%0d] ctl got %b want %b", i, ctl, e.ctl); end
      tests++;
      if (state !== e.st) begin failed++; $display("FAIL back_to_back[%0d] state got %0d want %0d", i, state, e.st); end
      tests++;
      if (stall_count !== e.cnt) begin failed++; $display("FAIL back_to_back[%0d] count got %0d want %0d", i, stall_count, e.cnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0;
    id_rs1 = 5'd0;
    id_rs2 = 5'd0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    ex_valid = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd = 5'd0;
    ex_redirect = 1'b0;
    dmem_req = 1'b0;
    dmem_ack = 1'b0;
    test_reset();
    test_load_use();
    test_flush();
    test_mem_wait();
    test_redirect_mem();
    test_flush_mem();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, legal range 1..3: number of consecutive cycles IF/ID is flushed per redirect.
REQ-002 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_id_valid  in  1  ID-stage instruction valid.
REQ-005 i_id_rs1, i_id_rs2  in  5 each  ID-stage source register indices.
REQ-006 i_id_uses_rs1, i_id_uses_rs2  in  1 each  ID instruction reads rs1/rs2.
REQ-007 i_ex_valid, i_ex_mem_read  in  1 each  EX instruction valid; EX instruction is a load.
REQ-008 i_ex_rd  in  5  EX destination register index.
REQ-009 i_ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
REQ-010 i_dmem_req, i_dmem_ack  in  1 each  MEM-stage data access pending; access completes this cycle.
REQ-011 o_pc_hold  out  1  freeze PC.
REQ-012 o_ifid_hold  out  1  IF/ID keeps current contents.
REQ-013 o_ifid_flush  out  1  IF/ID loads NOP (0x00000013, valid=0).
REQ-014 o_idex_bubble  out  1  ID/EX loads a bubble.
REQ-015 o_mem_stall  out  1  freeze EX/MEM and all upstream registers.
REQ-016 o_state  out  2  current state: 0 RUN, 1 FLUSH, 2 MEM_WAIT.
REQ-017 o_stall_count  out  32  cycles with o_pc_hold=1 since reset.

Function
REQ-018 Control outputs are combinational from state, flush counter and inputs; state, counter and o_stall_count are registered.
REQ-019 Load-use hazard = i_ex_valid & i_ex_mem_read & (i_ex_rd!=0) & i_id_valid & ((i_id_uses_rs1 & i_id_rs1==i_ex_rd) | (i_id_uses_rs2 & i_id_rs2==i_ex_rd)).
REQ-020 Mem stall condition = i_dmem_req & ~i_dmem_ack.
REQ-021 Priority, highest first: MEM_WAIT state or mem stall condition, then redirect or FLUSH state, then load-use.
REQ-022 RUN, mem stall condition: o_mem_stall=o_pc_hold=o_ifid_hold=1, flush/bubble 0; next state MEM_WAIT.
REQ-023 RUN, i_ex_redirect, no mem stall: o_ifid_flush=o_idex_bubble=1, holds 0; next state FLUSH with counter=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay RUN.
REQ-024 RUN, load-use only: o_pc_hold=o_ifid_hold=o_idex_bubble=1 for that cycle; state stays RUN.
REQ-025 FLUSH: o_ifid_flush=o_idex_bubble=1, counter decrements each cycle; counter reaching 0 at end of cycle returns to RUN; load-use and new redirects are ignored.
REQ-026 FLUSH with mem stall condition: mem stall response per REQ-022, counter frozen, return to FLUSH after ack.
REQ-027 MEM_WAIT: o_mem_stall=o_pc_hold=o_ifid_hold=1 while i_dmem_ack=0; in ack cycle all outputs 0 and next state is the pre-stall state (RUN or FLUSH).
REQ-028 o_ifid_hold and o_ifid_flush are never simultaneously 1.
REQ-029 o_stall_count increments by 1 each cycle o_pc_hold=1, saturating at 0xFFFFFFFF.
REQ-030 i_dmem_ack with i_dmem_req=0 in RUN is ignored.

Reset
REQ-031 While i_rst=1, all control outputs are 0.
REQ-032 On the first edge with i_rst=1: state RUN, counter 0, o_stall_count 0.
REQ-033 Reset asserted in MEM_WAIT or FLUSH aborts it; first cycle after reset is RUN with no holds or flushes.

Verification
REQ-034 Load x5 in EX (rd=5), ID uses rs2=5 -> one cycle pc_hold/ifid_hold/idex_bubble=1; next cycle (load gone) all 0; o_stall_count=1.
REQ-035 Load rd=0, ID rs1=0 -> no stall outputs.
REQ-036 FLUSH_CYCLES=2, redirect pulse -> o_ifid_flush=1 for 2 cycles; o_state 0,1,0.
REQ-037 dmem_req held with ack after 3 cycles -> o_mem_stall=1 for 3 cycles, 0 in ack cycle; o_stall_count +3.
REQ-038 Redirect and mem stall in same cycle -> mem stall only; redirect flush occurs in cycle after ack.
REQ-039 Reset during MEM_WAIT -> o_state=0, o_stall_count=0, all controls 0 after the reset edge.
